// File: rtl/airbag_pkg.sv
// Shared types and constants for the airbag deployment sequencer.
// The state encoding is visible on the debug port, so the values are fixed.
package airbag_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CONFIRM = 3'd2,
        ST_FIRE1   = 3'd3,
        ST_GAP     = 3'd4,
        ST_FIRE2   = 3'd5,
        ST_LOCKOUT = 3'd6
    } state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_FIRE_CYCLES     = 3;
    localparam int DEF_STAGE2_DELAY    = 5;
    localparam int DEF_CNT_W           = 8;

    localparam int                  ABORT_W   = 4;
    localparam logic [ABORT_W-1:0]  ABORT_MAX = 4'd15;

    // Saturating abort count; a same-cycle clear takes priority over an increment.
    function automatic logic [ABORT_W-1:0] abort_next(
        input logic [ABORT_W-1:0] cnt,
        input logic               inc,
        input logic               clr
    );
        logic [ABORT_W-1:0] res;
        res = cnt;
        if (clr) begin
            res = '0;
        end else if (inc && (cnt != ABORT_MAX)) begin
            res = cnt + 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/airbag_timer.sv
// Shared phase timer: loadable, incrementing counter with an equality compare
// against a terminal value chosen by the sequencer for the current phase.
module airbag_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic [CNT_W-1:0] term_val_i,
    output logic             at_term_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (inc_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign at_term_o = (count_q == term_val_i);

endmodule

// File: rtl/airbag_deploy_sequencer.sv
// Airbag deployment sequencer: armed/debounced trigger qualification, then a
// non-abortable two-stage squib sequence ending in a latched lockout.
module airbag_deploy_sequencer
    import airbag_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int FIRE_CYCLES     = DEF_FIRE_CYCLES,
    parameter int STAGE2_DELAY    = DEF_STAGE2_DELAY,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sensor,
    input  logic               seatbelt,
    input  logic               brake,
    input  logic               arm_en,
    input  logic               clear,
    output logic               fire_stage1,
    output logic               fire_stage2,
    output logic               deployed,
    output logic [2:0]         state,
    output logic [ABORT_W-1:0] abort_cnt
);

    localparam logic [CNT_W-1:0] TERM_CONFIRM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TERM_FIRE    = CNT_W'(FIRE_CYCLES);
    localparam logic [CNT_W-1:0] TERM_GAP     = CNT_W'(STAGE2_DELAY);
    localparam logic [CNT_W-1:0] TMR_START    = CNT_W'(1);

    state_e             state_q;
    logic               fire1_q;
    logic               fire2_q;
    logic               deployed_q;
    logic [ABORT_W-1:0] abort_q;

    logic               trig;
    logic               abort_evt;
    logic               tmr_load;
    logic               tmr_inc;
    logic               tmr_done;
    logic [CNT_W-1:0]   tmr_term;

    assign trig = sensor & seatbelt & brake;

    // Terminal value depends only on the current state, never on the timer itself.
    always_comb begin
        tmr_term = TERM_FIRE;
        if (state_q == ST_CONFIRM) begin
            tmr_term = TERM_CONFIRM;
        end else if (state_q == ST_GAP) begin
            tmr_term = TERM_GAP;
        end
    end

    always_comb begin
        tmr_load  = 1'b0;
        tmr_inc   = 1'b0;
        abort_evt = 1'b0;
        case (state_q)
            ST_ARMED: begin
                tmr_load = arm_en & trig;
            end
            ST_CONFIRM: begin
                if (!trig) begin
                    abort_evt = 1'b1;
                end else if (arm_en) begin
                    tmr_load = tmr_done;
                    tmr_inc  = ~tmr_done;
                end
            end
            ST_FIRE1, ST_GAP, ST_FIRE2: begin
                tmr_load = tmr_done;
                tmr_inc  = ~tmr_done;
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    airbag_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .inc_i      (tmr_inc),
        .load_val_i (TMR_START),
        .term_val_i (tmr_term),
        .at_term_o  (tmr_done)
    );

    // Output flags default low each cycle and are raised by the branch entering
    // or holding the matching state, so they always track the registered state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fire1_q    <= 1'b0;
            fire2_q    <= 1'b0;
            deployed_q <= 1'b0;
        end else begin
            fire1_q    <= 1'b0;
            fire2_q    <= 1'b0;
            deployed_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arm_en) begin
                        state_q <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (!arm_en) begin
                        state_q <= ST_IDLE;
                    end else if (trig) begin
                        state_q <= ST_CONFIRM;
                    end
                end
                ST_CONFIRM: begin
                    if (!trig) begin
                        state_q <= ST_ARMED;
                    end else if (!arm_en) begin
                        state_q <= ST_IDLE;
                    end else if (tmr_done) begin
                        state_q <= ST_FIRE1;
                        fire1_q <= 1'b1;
                    end
                end
                ST_FIRE1: begin
                    if (tmr_done) begin
                        state_q <= ST_GAP;
                    end else begin
                        fire1_q <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tmr_done) begin
                        if (seatbelt) begin
                            state_q <= ST_FIRE2;
                            fire2_q <= 1'b1;
                        end else begin
                            state_q    <= ST_LOCKOUT;
                            deployed_q <= 1'b1;
                        end
                    end
                end
                ST_FIRE2: begin
                    if (tmr_done) begin
                        state_q    <= ST_LOCKOUT;
                        deployed_q <= 1'b1;
                    end else begin
                        fire2_q <= 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    if (clear && !arm_en) begin
                        state_q <= ST_IDLE;
                    end else begin
                        deployed_q <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: fail safe into a deployed lockout.
                    state_q    <= ST_LOCKOUT;
                    deployed_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort_q <= '0;
        end else begin
            abort_q <= abort_next(abort_q, abort_evt, clear);
        end
    end

    assign fire_stage1 = fire1_q;
    assign fire_stage2 = fire2_q;
    assign deployed    = deployed_q;
    assign state       = state_q;
    assign abort_cnt   = abort_q;

endmodule

// File: tb/tb_airbag_deploy_sequencer.sv
// Bench for airbag_deploy_sequencer: timeline-based reference model feeding an
// expected queue, with a negedge monitor comparing the DUT each cycle.
module tb_airbag_deploy_sequencer;

    localparam int D = 4;
    localparam int F = 3;
    localparam int G = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sensor = 1'b0;
    logic       seatbelt = 1'b0;
    logic       brake = 1'b0;
    logic       arm_en = 1'b0;
    logic       clear = 1'b0;
    logic       fire_stage1;
    logic       fire_stage2;
    logic       deployed;
    logic [2:0] state;
    logic [3:0] abort_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    logic [9:0] exp_q[$];

    airbag_deploy_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sensor      (sensor),
        .seatbelt    (seatbelt),
        .brake       (brake),
        .arm_en      (arm_en),
        .clear       (clear),
        .fire_stage1 (fire_stage1),
        .fire_stage2 (fire_stage2),
        .deployed    (deployed),
        .state       (state),
        .abort_cnt   (abort_cnt)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        tests_failed++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // ---------------- reference model ----------------
    // m_fire_t counts edges since the sequence started (0 = first stage-1 cycle).
    bit m_armed;
    bit m_locked;
    int m_streak;
    int m_fire_t;
    int m_aborts;

    task automatic model_reset();
        m_armed  = 1'b0;
        m_locked = 1'b0;
        m_streak = 0;
        m_fire_t = -1;
        m_aborts = 0;
    endtask

    task automatic model_step(input bit s, input bit b, input bit br, input bit a, input bit c);
        bit trig;
        bit abort_ev;
        trig = s & b & br;
        abort_ev = 1'b0;
        if (m_locked) begin
            if (c && !a) begin
                m_locked = 1'b0;
                m_armed  = 1'b0;
            end
        end else if (m_fire_t >= 0) begin
            m_fire_t++;
            if (m_fire_t == F + G && !b) begin
                m_fire_t = -1;
                m_locked = 1'b1;
            end else if (m_fire_t == 2 * F + G) begin
                m_fire_t = -1;
                m_locked = 1'b1;
            end
        end else if (m_streak > 0) begin
            if (!trig) begin
                m_streak = 0;
                abort_ev = 1'b1;
            end else if (!a) begin
                m_streak = 0;
                m_armed  = 1'b0;
            end else if (m_streak == D - 1) begin
                m_streak = 0;
                m_fire_t = 0;
            end else begin
                m_streak++;
            end
        end else if (m_armed) begin
            if (!a) m_armed = 1'b0;
            else if (trig) m_streak = 1;
        end else if (a) begin
            m_armed = 1'b1;
        end
        if (c) m_aborts = 0;
        else if (abort_ev && m_aborts < 15) m_aborts++;
    endtask

    function automatic logic [9:0] model_out();
        int st;
        bit f1;
        bit f2;
        if (m_locked) st = 6;
        else if (m_fire_t >= 0) st = (m_fire_t < F) ? 3 : ((m_fire_t < F + G) ? 4 : 5);
        else if (m_streak > 0) st = 2;
        else if (m_armed) st = 1;
        else st = 0;
        f1 = (m_fire_t >= 0) && (m_fire_t < F);
        f2 = (m_fire_t >= F + G);
        return {3'(st), f1, f2, m_locked, 4'(m_aborts)};
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input bit s, input bit b, input bit br, input bit a, input bit c);
        sensor   = s;
        seatbelt = b;
        brake    = br;
        arm_en   = a;
        clear    = c;
        @(posedge clk);
        model_step(s, b, br, a, c);
        exp_q.push_back(model_out());
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("queue_drain", exp_q.size(), 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [9:0] e;
        logic [9:0] act;
        if (rst_n && exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {state, fire_stage1, fire_stage2, deployed, abort_cnt};
            tests_run++;
            if (act !== e) begin
                tests_failed++;
                $display("FAIL cycle @%0t: got st=%0d f1=%b f2=%b dep=%b ab=%0d expected st=%0d f1=%b f2=%b dep=%b ab=%0d",
                         $time, act[9:7], act[6], act[5], act[4], act[3:0],
                         e[9:7], e[6], e[5], e[4], e[3:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        #12;
        check("reset_outputs", {29'd0, state}, 32'd0);
        check("reset_flags", {fire_stage1, fire_stage2, deployed, abort_cnt}, 7'd0);
        #10;
        rst_n = 1'b1;

        // Full deployment, then lockout exit
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++) drive(1, 1, 1, 1, 0);
        drain();
        check("full_deployed", {state, deployed}, {3'd6, 1'b1});
        drive(0, 0, 0, 1, 1);
        drain();
        check("lockout_hold_armed_clear", state, 3'd6);
        drive(0, 0, 0, 0, 1);
        drain();
        check("lockout_exit", {state, deployed}, {3'd0, 1'b0});

        // Spurious triggers until saturation, then clear
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 17; i++) begin
            drive(1, 1, 1, 1, 0);
            drive(1, 1, 1, 1, 0);
            drive(0, 1, 1, 1, 0);
        end
        drain();
        check("abort_saturated", {state, abort_cnt}, {3'd1, 4'd15});
        drive(0, 0, 0, 1, 1);
        drain();
        check("abort_cleared", abort_cnt, 4'd0);

        // Seatbelt released at the gap exit edge
        for (int i = 0; i < 11; i++) drive(1, 1, 1, 1, 0);
        drive(1, 0, 1, 1, 0);
        drain();
        check("belt_release_lockout", {state, deployed, fire_stage2}, {3'd6, 1'b1, 1'b0});
        drive(0, 0, 0, 0, 1);

        // Unarmed with trigger held
        for (int i = 0; i < 20; i++) drive(1, 1, 1, 0, 0);
        drain();
        check("unarmed_idle", {state, fire_stage1, fire_stage2, deployed}, 6'd0);

        // Reset during stage 1
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) drive(1, 1, 1, 1, 0);
        drain();
        check("pre_reset_fire1", fire_stage1, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_reset_fire1", fire_stage1, 1'b0);
        check("async_reset_state", state, 3'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) drive(1, 1, 1, 1, 0);
        drain();
        check("post_reset_fire1", fire_stage1, 1'b1);
        drive(0, 0, 0, 1, 0);
        drain();
        rst_n = 1'b0;
        #1;
        model_reset();
        #2;
        rst_n = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
